clk_gate_ctrl: RTL
==================

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 SHALL have parameter IDLE_THRESH, default 8: consecutive idle cycles (range 1..255) before the clock is gated.
REQ-002 SHALL have parameter WAKE_DLY, default 2: cycles (range 1..15) the clock runs after ungating before ready asserts.
REQ-003 SHALL have port forever_cpuclk, input, 1 bit: the single free-running clock; all logic is on its rising edge.
REQ-004 SHALL have port cpurst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port mod_busy, input, 1 bit: the downstream module has work in flight.
REQ-006 SHALL have port wake_req, input, 1 bit: new work is pending for the gated module (level).
REQ-007 SHALL have port pm_sleep_req, input, 1 bit: power-management request to gate immediately (level).
REQ-008 SHALL have port icg_force_on, input, 1 bit: global gating disable.
REQ-009 SHALL have port clk_en, output, 1 bit: registered enable driven into the CE pin of the downstream latch-based gate cell.
REQ-010 SHALL have port mod_ready, output, 1 bit: the gated clock is stable and the module may accept work.
REQ-011 SHALL have port pm_sleep_ack, output, 1 bit: the clock is gated in response to pm_sleep_req.
REQ-012 SHALL have port gated_cycles, output, 32 bits: count of cycles spent gated (see Configuration).

Function
REQ-013 SHALL implement an FSM with four states: RUN, IDLE, OFF, WAKE. All outputs are registered or decoded from state only.
REQ-014 In RUN: clk_en=1, mod_ready=1. If mod_busy=0, wake_req=0 and icg_force_on=0, go to IDLE with the counter cleared; otherwise stay in RUN.
REQ-015 In IDLE: clk_en=1, mod_ready=1, and the counter increments each cycle.
  - mod_busy, wake_req or icg_force_on: go to RUN.
  - Otherwise, counter==IDLE_THRESH-1 or pm_sleep_req=1: go to OFF.
REQ-016 Priority in IDLE SHALL be busy/wake/force over sleep; a simultaneous mod_busy and pm_sleep_req keeps the clock on.
REQ-017 In OFF: clk_en=0, mod_ready=0.
  - Go to WAKE when icg_force_on=1, or when wake_req=1 and pm_sleep_req=0.
  - wake_req is ignored while pm_sleep_req=1.
REQ-018 In WAKE: clk_en=1, mod_ready=0. The counter counts WAKE_DLY cycles, then the FSM goes to RUN; pm_sleep_req does not abort WAKE.
REQ-019 clk_en SHALL fall on the cycle after OFF is entered and rise on the cycle after WAKE is entered. Gate-off latency from the last idle cycle is IDLE_THRESH+1 cycles.
REQ-020 pm_sleep_ack SHALL be 1 exactly when state==OFF and pm_sleep_req=1, and drop the cycle after pm_sleep_req drops.
REQ-021 The counter SHALL be 8 bits and never wrap. It is cleared on every state transition and holds at its terminal value.
REQ-022 A glitch-free enable SHALL be guaranteed: clk_en changes only on forever_cpuclk rising edges.

Reset
REQ-023 On cpurst=1 at a clock edge: state=RUN, counter=0, clk_en=1, mod_ready=1, pm_sleep_ack=0, gated_cycles=0.
REQ-024 Reset asserted in any state, including OFF or WAKE, SHALL return to RUN on the next edge with the clock enabled.

Configuration
REQ-025 Macro CLK_GATE_STATS_EN, when defined, SHALL make gated_cycles increment once per cycle while state==OFF, saturating at 0xFFFFFFFF and cleared only by reset.
REQ-026 Without CLK_GATE_STATS_EN, the gated_cycles port SHALL remain present, tied to 0, with no counter flops.

Structure
REQ-027 Package clk_gate_pkg SHALL hold the state encoding (2-bit enum), counter width (8), and stats width (32).
REQ-028 Sub-module clk_gate_cnt (clear/increment/terminal-compare counter) SHALL be shared by the IDLE and WAKE timing.
REQ-029 The gate cell itself is not instantiated; clk_en is the block output.

Verification
REQ-030 Idle timeout: reset, then mod_busy=0 and wake_req=0 -> clk_en=0 exactly 9 cycles after reset release (IDLE_THRESH=8); mod_ready=0.
REQ-031 Wake: from OFF, pulse wake_req=1 for 1 cycle -> clk_en=1 next cycle, mod_ready=1 after 2 further cycles (WAKE_DLY=2).
REQ-032 Sleep handshake: in IDLE, raise pm_sleep_req -> OFF next cycle, pm_sleep_ack=1. Assert wake_req while pm_sleep_req=1 -> stays OFF. Drop pm_sleep_req with wake_req=1 -> ack=0, then WAKE.
REQ-033 Simultaneous: in IDLE, mod_busy=1 and pm_sleep_req=1 in the same cycle -> RUN, clk_en stays 1.
REQ-034 Mid-operation reset: assert cpurst during OFF and during WAKE -> next cycle clk_en=1, mod_ready=1, pm_sleep_ack=0.
REQ-035 Stats: with CLK_GATE_STATS_EN, hold OFF for 100 cycles -> gated_cycles=100. Without the macro -> gated_cycles=0 throughout.

Source files
------------

// File: rtl/clk_gate_pkg.sv
// Shared types and widths for the clk_gate_ctrl clock-gating controller.
package clk_gate_pkg;

  localparam int CNT_W   = 8;
  localparam int STATS_W = 32;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_IDLE = 2'd1,
    ST_OFF  = 2'd2,
    ST_WAKE = 2'd3
  } gate_state_e;

endpackage

// File: rtl/clk_gate_cnt.sv
// Clear/increment/terminal-compare counter shared by the idle timeout and wake delay.
module clk_gate_cnt
  import clk_gate_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] count,
  output logic             at_term
);

  assign at_term = (count == term);

  // Holds at the terminal value instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_term) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Idle-timeout clock-gating controller producing a registered CE for a latch-based gate cell.
// Optional gated-cycle statistics counter enabled by defining CLK_GATE_STATS_EN.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int IDLE_THRESH = 8,
  parameter int WAKE_DLY    = 2
) (
  input  logic               forever_cpuclk,
  input  logic               cpurst,
  input  logic               mod_busy,
  input  logic               wake_req,
  input  logic               pm_sleep_req,
  input  logic               icg_force_on,
  output logic               clk_en,
  output logic               mod_ready,
  output logic               pm_sleep_ack,
  output logic [STATS_W-1:0] gated_cycles
);

  localparam logic [CNT_W-1:0] IDLE_TERM = CNT_W'(IDLE_THRESH - 1);
  localparam logic [CNT_W-1:0] WAKE_TERM = CNT_W'(WAKE_DLY - 1);

  gate_state_e      state;
  gate_state_e      state_nxt;
  logic             cnt_clr;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt_term;
  logic [CNT_W-1:0] cnt;
  logic             cnt_at_term;

  assign cnt_term = (state == ST_WAKE) ? WAKE_TERM : IDLE_TERM;
  assign cnt_clr  = (state_nxt != state);

  clk_gate_cnt u_cnt (
    .clk     (forever_cpuclk),
    .rst     (cpurst),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .term    (cnt_term),
    .count   (cnt),
    .at_term (cnt_at_term)
  );

  always_comb begin
    state_nxt = state;
    cnt_inc   = 1'b0;
    case (state)
      ST_RUN: begin
        if (!mod_busy && !wake_req && !icg_force_on) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        cnt_inc = 1'b1;
        // Keeping the clock on wins over any sleep request.
        if (mod_busy || wake_req || icg_force_on) begin
          state_nxt = ST_RUN;
        end else if (cnt_at_term || pm_sleep_req) begin
          state_nxt = ST_OFF;
        end
      end
      ST_OFF: begin
        if (icg_force_on || (wake_req && !pm_sleep_req)) state_nxt = ST_WAKE;
      end
      ST_WAKE: begin
        cnt_inc = 1'b1;
        if (cnt_at_term) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Enables are registered from the current state so CE only moves on a rising edge.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state        <= ST_RUN;
      clk_en       <= 1'b1;
      mod_ready    <= 1'b1;
      pm_sleep_ack <= 1'b0;
    end else begin
      state        <= state_nxt;
      clk_en       <= (state != ST_OFF);
      mod_ready    <= (state == ST_RUN) || (state == ST_IDLE);
      pm_sleep_ack <= (state_nxt == ST_OFF) && pm_sleep_req;
    end
  end

`ifdef CLK_GATE_STATS_EN
  logic [STATS_W-1:0] gated_cnt;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      gated_cnt <= '0;
    end else if ((state == ST_OFF) && (gated_cnt != {STATS_W{1'b1}})) begin
      gated_cnt <= gated_cnt + 1'b1;
    end
  end

  assign gated_cycles = gated_cnt;
`else
  assign gated_cycles = '0;
`endif

endmodule
